// File: rtl/sm_pkg.sv
// Shared types and helpers for the pipelined sign-magnitude adder/accumulator.
package sm_pkg;

    typedef enum logic [1:0] {
        SM_ADD = 2'd0,
        SM_SUB = 2'd1,
        SM_ACC = 2'd2,
        SM_CLR = 2'd3
    } sm_op_e;

    localparam logic SM_SIGN_POS = 1'b0;
    localparam int   SM_STAGES   = 2;

    // Callers size-cast their magnitude to 64 bits so one helper covers any width.
    function automatic logic sm_is_zero(input logic [63:0] mag);
        return mag == 64'd0;
    endfunction

endpackage

// File: rtl/sm_magcore.sv
// Combinational sign-magnitude core: one adder chain serves both add and
// subtract; a negative difference is fixed up by invert-and-increment.
module sm_magcore
    import sm_pkg::*;
#(
    parameter int M   = 7,
    parameter bit SAT = 1'b1
) (
    input  logic         sa,
    input  logic [M-1:0] ma,
    input  logic         sb,
    input  logic [M-1:0] mb,
    output logic         sy,
    output logic [M-1:0] my,
    output logic         ovf
);

    logic         diff;
    logic [M-1:0] opb;
    logic [M-1:0] sum;
    logic [M-1:0] neg;
    logic [M:0]   c;

    assign diff = sa ^ sb;
    assign opb  = mb ^ {M{diff}};
    assign c[0] = diff;

    for (genvar i = 0; i < M; i++) begin : g_fa
        assign sum[i]   = ma[i] ^ opb[i] ^ c[i];
        assign c[i+1]   = (ma[i] & opb[i]) | (c[i] & (ma[i] ^ opb[i]));
    end

    assign neg = ~sum + {{(M-1){1'b0}}, 1'b1};

    // With differing signs the carry out means ma >= mb, so no fix-up is needed.
    always_comb begin
        sy  = sa;
        my  = sum;
        ovf = 1'b0;
        if (!diff) begin
            ovf = c[M];
            if (c[M] && SAT)
                my = '1;
        end else if (!c[M]) begin
            my = neg;
            sy = sb;
        end
        if (sm_is_zero(64'(my)))
            sy = SM_SIGN_POS;
    end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude add/sub/accumulate pipeline with valid/ready on
// both sides; the accumulator lives alongside the output register.
module sm_addsub_pipe
    import sm_pkg::*;
#(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf
);

    localparam int M = W - 1;

    logic [SM_STAGES:1] vld_pipe;
    sm_op_e             s1_op;
    logic [W-1:0]       s1_a, s1_b, acc;
    logic               adv, accept;
    logic               a_sign, b_sign;
    logic [W-1:0]       opnd, res_y;
    logic               res_ovf, c_sy, c_ovf;
    logic [M-1:0]       c_my;

    assign out_valid = vld_pipe[SM_STAGES];
    assign adv       = !vld_pipe[SM_STAGES] || out_ready;
    assign in_ready  = !vld_pipe[1] || adv;
    assign accept    = in_valid && in_ready;

    // Zero magnitudes enter as +0; SUB is folded into an ADD with b negated.
    assign a_sign = sm_is_zero(64'(a[M-1:0])) ? SM_SIGN_POS : a[W-1];
    assign b_sign = sm_is_zero(64'(b[M-1:0])) ? SM_SIGN_POS
                                               : (b[W-1] ^ (sm_op_e'(op) == SM_SUB));

    // acc is read here rather than in stage 1, so chained ACCs see the fresh value.
    assign opnd = (s1_op == SM_ACC) ? acc : s1_b;

    sm_magcore #(.M(M), .SAT(SAT)) u_core (
        .sa  (s1_a[W-1]),
        .ma  (s1_a[M-1:0]),
        .sb  (opnd[W-1]),
        .mb  (opnd[M-1:0]),
        .sy  (c_sy),
        .my  (c_my),
        .ovf (c_ovf)
    );

    assign res_y   = (s1_op == SM_CLR) ? '0 : {c_sy, c_my};
    assign res_ovf = (s1_op != SM_CLR) && c_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1_op    <= SM_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            y        <= '0;
            ovf      <= 1'b0;
            acc      <= '0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (accept) begin
                    s1_op <= sm_op_e'(op);
                    s1_a  <= {a_sign, a[M-1:0]};
                    s1_b  <= {b_sign, b[M-1:0]};
                end
            end
            if (adv) begin
                vld_pipe[SM_STAGES] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    y   <= res_y;
                    ovf <= res_ovf;
                    if (s1_op == SM_ACC || s1_op == SM_CLR)
                        acc <= res_y;
                end
            end
        end
    end

endmodule
